// File: rtl/card_dealer.sv
// ============================================================================
// card_dealer
// ----------------------------------------------------------------------------
// Card source for the blackjack game FSM.  Holds one 52-card deck and deals
// cards without replacement.  A free-running 16-bit Galois LFSR picks a
// starting slot; the dealer then probes linearly (wrapping 51 -> 0) until it
// finds a slot that has not been drawn yet, marks it used and presents the
// card's deck index, rank and blackjack point value for one cycle.
//
// Parameters:
//   SEED       LFSR reset value (a zero seed is replaced by 16'h0001)
//   DECK_SIZE  number of cards, fixed at 52 (4 suits x 13 ranks)
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   shuffle     in   single-cycle pulse, restores the full deck (any state)
//   req         in   single-cycle pulse, requests one card
//   card_valid  out  one-cycle pulse, card outputs are valid
//   card_index  out  drawn deck slot 0..51 (suit = index/13, rank-1 = index%13)
//   card_rank   out  1..13 (A=1, J=11, Q=12, K=13)
//   card_value  out  blackjack points: A=1, 2..10 = rank, J/Q/K = 10
//   cards_left  out  undrawn cards, 0..52
//   deck_empty  out  high when cards_left == 0
//   busy        out  high while a draw is in progress
//
// Build option:
//   CARD_DEALER_AUTO_SHUFFLE_EN
//     Defined   : req on an empty deck refills the deck that cycle, spends one
//                 cycle in REFILL and then probes; deck_empty falls the cycle
//                 after req and the draw takes one extra cycle.
//     Undefined : req on an empty deck is ignored and deck_empty stays high.
// ============================================================================
module card_dealer #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          DECK_SIZE = 52
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shuffle,
    input  logic       req,
    output logic       card_valid,
    output logic [5:0] card_index,
    output logic [3:0] card_rank,
    output logic [3:0] card_value,
    output logic [5:0] cards_left,
    output logic       deck_empty,
    output logic       busy
);

    // An all-zero Galois LFSR would lock up, so a zero seed is remapped.
    localparam logic [15:0] LFSR_INIT  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [5:0]  FULL_COUNT = 6'(DECK_SIZE);
    localparam logic [5:0]  LAST_SLOT  = 6'(DECK_SIZE - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PROBE   = 2'd1;
    localparam logic [1:0] S_DELIVER = 2'd2;
`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
    localparam logic [1:0] S_REFILL  = 2'd3;
`endif

    logic [1:0]           state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [DECK_SIZE-1:0] used_q, used_d;
    logic [5:0]           ptr_q, ptr_d;
    logic [5:0]           left_q, left_d;
    logic [5:0]           index_q, index_d;
    logic [3:0]           rank_q, rank_d;
    logic [3:0]           value_q, value_d;

    // Fold the 6-bit LFSR slice (0..63) into the deck range 0..51.
    function automatic logic [5:0] start_slot(input logic [5:0] raw);
        return (raw >= FULL_COUNT) ? (raw - FULL_COUNT) : raw;
    endfunction

    // index % 13 without a divider: at most one suit offset is subtracted,
    // chosen by comparing against the suit boundaries 39, 26 and 13.
    function automatic logic [3:0] rank_of(input logic [5:0] idx);
        logic [5:0] rem;
        if (idx >= 6'd39) begin
            rem = idx - 6'd39;
        end else if (idx >= 6'd26) begin
            rem = idx - 6'd26;
        end else if (idx >= 6'd13) begin
            rem = idx - 6'd13;
        end else begin
            rem = idx;
        end
        return 4'(rem) + 4'd1;
    endfunction

    // Face cards and tens are all worth ten points.
    function automatic logic [3:0] value_of(input logic [3:0] rank);
        return (rank >= 4'd10) ? 4'd10 : rank;
    endfunction

    // Next-state logic.  The LFSR steps every cycle regardless of state so the
    // starting slot depends on when the request arrives.  Shuffle is checked
    // first and overrides everything: it drops a same-cycle req, aborts a probe
    // without touching the mask or the card outputs, and clears the slot that
    // was just delivered if it lands in the DELIVER cycle.
    always_comb begin
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        state_d = state_q;
        used_d  = used_q;
        ptr_d   = ptr_q;
        left_d  = left_q;
        index_d = index_q;
        rank_d  = rank_q;
        value_d = value_q;

        if (shuffle) begin
            used_d  = '0;
            left_d  = FULL_COUNT;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req && (left_q != 6'd0)) begin
                        state_d = S_PROBE;
                        ptr_d   = start_slot(lfsr_q[5:0]);
                    end
`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
                    else if (req) begin
                        used_d  = '0;
                        left_d  = FULL_COUNT;
                        state_d = S_REFILL;
                    end
`endif
                end

                // One slot per cycle.  The deck is never empty here, so the
                // walk always terminates within 52 probes.
                S_PROBE: begin
                    if (!used_q[ptr_q]) begin
                        used_d[ptr_q] = 1'b1;
                        if (left_q != 6'd0) begin
                            left_d = left_q - 6'd1;
                        end
                        index_d = ptr_q;
                        rank_d  = rank_of(ptr_q);
                        value_d = value_of(rank_of(ptr_q));
                        state_d = S_DELIVER;
                    end else begin
                        ptr_d = (ptr_q == LAST_SLOT) ? 6'd0 : (ptr_q + 6'd1);
                    end
                end

                S_DELIVER: begin
                    state_d = S_IDLE;
                end

`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
                // The deck was refilled last cycle; pick the start slot from
                // the LFSR value of this cycle.
                S_REFILL: begin
                    state_d = S_PROBE;
                    ptr_d   = start_slot(lfsr_q[5:0]);
                end
`endif

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers, all returned to their reset values asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_INIT;
            used_q  <= '0;
            ptr_q   <= 6'd0;
            left_q  <= FULL_COUNT;
            index_q <= 6'd0;
            rank_q  <= 4'd0;
            value_q <= 4'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            used_q  <= used_d;
            ptr_q   <= ptr_d;
            left_q  <= left_d;
            index_q <= index_d;
            rank_q  <= rank_d;
            value_q <= value_d;
        end
    end

    // All outputs are decodes of registers, so none depends combinationally
    // on req or shuffle.
    always_comb begin
        card_valid = (state_q == S_DELIVER);
`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
        busy       = (state_q == S_PROBE) || (state_q == S_REFILL);
`else
        busy       = (state_q == S_PROBE);
`endif
        card_index = index_q;
        card_rank  = rank_q;
        card_value = value_q;
        cards_left = left_q;
        deck_empty = (left_q == 6'd0);
    end

endmodule

// File: tb/tb_card_dealer.sv
// ============================================================================
// tb_card_dealer
// ----------------------------------------------------------------------------
// Self-checking bench for card_dealer.  A behavioural deck model (array of
// drawn flags, LFSR arithmetic, "first free slot at or after the start"
// search) predicts every output each cycle; directed sequences add literal
// expectations for the first card, deck totals and the shuffle/reset corners.
// ============================================================================
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       shuffle = 1'b0;
    logic       req = 1'b0;
    logic       card_valid;
    logic [5:0] card_index;
    logic [3:0] card_rank;
    logic [3:0] card_value;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    card_dealer #(.SEED(16'hACE1), .DECK_SIZE(52)) dut (
        .clk       (clk),
        .reset     (reset),
        .shuffle   (shuffle),
        .req       (req),
        .card_valid(card_valid),
        .card_index(card_index),
        .card_rank (card_rank),
        .card_value(card_value),
        .cards_left(cards_left),
        .deck_empty(deck_empty),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model of the deck.
    // ------------------------------------------------------------------------
    logic [15:0] m_lfsr;
    bit          m_used[52];
    int          m_left;
    bit          m_valid;
    bit          m_pending;
    bit          m_refill;
    int          m_count;
    int          m_target;
    int          m_idx;
    int          m_rank;
    int          m_value;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // The card that will be dealt is the first undrawn slot at or after the
    // start slot (wrapping); each skipped slot costs one extra cycle.
    task automatic modelStartDraw(input logic [15:0] lfsr_at_req);
        int s;
        int d;
        s = int'(lfsr_at_req[5:0]);
        if (s >= 52) s = s - 52;
        d = 0;
        while (m_used[(s + d) % 52]) d++;
        m_target  = (s + d) % 52;
        m_count   = d;
        m_pending = 1'b1;
    endtask

    // Model update on every rising edge, mirroring the async reset.
    always @(posedge clk or posedge reset) begin
        logic [15:0] old;
        bit          was_deliver;
        if (reset) begin
            m_lfsr = 16'hACE1;
            foreach (m_used[i]) m_used[i] = 1'b0;
            m_left    = 52;
            m_valid   = 1'b0;
            m_pending = 1'b0;
            m_refill  = 1'b0;
            m_count   = 0;
            m_target  = 0;
            m_idx     = 0;
            m_rank    = 0;
            m_value   = 0;
        end else begin
            old         = m_lfsr;
            m_lfsr      = lfsr_next(old);
            was_deliver = m_valid;
            m_valid     = 1'b0;
            if (shuffle) begin
                foreach (m_used[i]) m_used[i] = 1'b0;
                m_left    = 52;
                m_pending = 1'b0;
                m_refill  = 1'b0;
            end else if (m_refill) begin
                m_refill = 1'b0;
                modelStartDraw(old);
            end else if (m_pending) begin
                if (m_count == 0) begin
                    m_used[m_target] = 1'b1;
                    m_left    = m_left - 1;
                    m_idx     = m_target;
                    m_rank    = m_target % 13 + 1;
                    m_value   = (m_rank >= 10) ? 10 : m_rank;
                    m_valid   = 1'b1;
                    m_pending = 1'b0;
                end else begin
                    m_count = m_count - 1;
                end
            end else if (req && !was_deliver) begin
                if (m_left > 0) begin
                    modelStartDraw(old);
                end
`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
                else begin
                    foreach (m_used[i]) m_used[i] = 1'b0;
                    m_left   = 52;
                    m_refill = 1'b1;
                end
`endif
            end
        end
    end

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            checkOutput("card_valid", card_valid, m_valid);
            checkOutput("busy", busy, (m_pending || m_refill) ? 1 : 0);
            checkOutput("cards_left", cards_left, m_left);
            checkOutput("deck_empty", deck_empty, (m_left == 0) ? 1 : 0);
            checkOutput("card_index", card_index, m_idx);
            checkOutput("card_rank", card_rank, m_rank);
            checkOutput("card_value", card_value, m_value);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all called and returning on a falling edge).
    // ------------------------------------------------------------------------

    // One-cycle pulse on req and/or shuffle.
    task automatic applyStimulus(input bit r, input bit s);
        req     = r;
        shuffle = s;
        @(negedge clk);
        req     = 1'b0;
        shuffle = 1'b0;
    endtask

    // Hold reset two cycles, check the reset values, release on a falling edge.
    task automatic doReset();
        reset   = 1'b1;
        req     = 1'b0;
        shuffle = 1'b0;
        @(negedge clk);
        checkOutput("rst_card_valid", card_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cards_left", cards_left, 52);
        checkOutput("rst_deck_empty", deck_empty, 0);
        checkOutput("rst_card_index", card_index, 0);
        checkOutput("rst_card_rank", card_rank, 0);
        checkOutput("rst_card_value", card_value, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Request a card and wait (bounded) for card_valid; leaves the DUT idle.
    task automatic drawCard(output bit got, output int lat, output int idx,
                            output int rank, output int value);
        got = 1'b0; lat = 0; idx = 0; rank = 0; value = 0;
        req = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            if (card_valid) begin
                got = 1'b1; lat = c;
                idx = card_index; rank = card_rank; value = card_value;
                break;
            end
        end
        @(negedge clk);
    endtask

    // Count card_valid pulses over a window that must stay silent.
    task automatic waitNoValid(input int cycles, input string name);
        int cnt = 0;
        repeat (cycles) begin
            if (card_valid) cnt++;
            @(negedge clk);
        end
        checkOutput(name, cnt, 0);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence.
    // ------------------------------------------------------------------------
    initial begin
        bit got;
        int lat, idx, rank, value, sum, uniq;
        int seen[52];
        int run_a[8];

        doReset();
        cmp_en = 1'b1;

        // Full deck: 52 draws, each unique, latency in range, value rule.
        sum = 0;
        foreach (seen[i]) seen[i] = 0;
        for (int i = 0; i < 52; i++) begin
            drawCard(got, lat, idx, rank, value);
            checkOutput("draw_got", got, 1);
            checkOutput("draw_latency_in_range", (lat >= 2 && lat <= 53) ? 1 : 0, 1);
            checkOutput("value_vs_rank", value, (rank >= 10) ? 10 : rank);
            if (i == 0) begin
                checkOutput("first_index", idx, 33);
                checkOutput("first_rank", rank, 8);
                checkOutput("first_value", value, 8);
                checkOutput("first_latency", lat, 2);
            end
            if (idx < 52) seen[idx]++;
            sum += value;
        end
        uniq = 0;
        foreach (seen[i]) if (seen[i] == 1) uniq++;
        checkOutput("unique_indices", uniq, 52);
        checkOutput("value_sum", sum, 340);
        checkOutput("empty_cards_left", cards_left, 0);
        checkOutput("empty_flag", deck_empty, 1);

        // Request on an empty deck.
`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
        drawCard(got, lat, idx, rank, value);
        checkOutput("auto_shuffle_got", got, 1);
        checkOutput("auto_shuffle_left", cards_left, 51);
`else
        applyStimulus(1'b1, 1'b0);
        waitNoValid(60, "empty_req_no_valid");
        checkOutput("empty_req_flag", deck_empty, 1);
`endif

        // Plain shuffle restores the deck.
        applyStimulus(1'b0, 1'b1);
        checkOutput("shuffle_left", cards_left, 52);
        checkOutput("shuffle_empty", deck_empty, 0);

        // Ten draws, then shuffle and req together: shuffle wins.
        for (int i = 0; i < 10; i++) begin
            drawCard(got, lat, idx, rank, value);
            checkOutput("draw10_got", got, 1);
        end
        checkOutput("after10_left", cards_left, 42);
        applyStimulus(1'b1, 1'b1);
        waitNoValid(20, "shuffle_req_no_valid");
        checkOutput("shuffle_req_left", cards_left, 52);
        drawCard(got, lat, idx, rank, value);
        checkOutput("after_shuffle_got", got, 1);
        checkOutput("after_shuffle_left", cards_left, 51);

        // Shuffle one cycle after req, while probing: draw aborted.
        for (int i = 0; i < 3; i++) drawCard(got, lat, idx, rank, value);
        checkOutput("before_abort_left", cards_left, 48);
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy_in_probe", busy, 1);
        applyStimulus(1'b0, 1'b1);
        waitNoValid(60, "abort_no_valid");
        checkOutput("abort_left", cards_left, 52);
        checkOutput("abort_busy", busy, 0);

        // Shuffle in the DELIVER cycle: pulse still seen, deck fully restored.
        drawCard(got, lat, idx, rank, value);
        checkOutput("pre_deliver_left", cards_left, 51);
        got = 1'b0;
        req = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            if (card_valid) begin
                got = 1'b1;
                break;
            end
        end
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        checkOutput("deliver_shuffle_got", got, 1);
        checkOutput("deliver_shuffle_left", cards_left, 52);
        @(negedge clk);

        // Reset three cycles after a req: outputs return at once, no card.
        drawCard(got, lat, idx, rank, value);
        drawCard(got, lat, idx, rank, value);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_valid", card_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_left", cards_left, 52);
        checkOutput("midrst_empty", deck_empty, 0);
        checkOutput("midrst_index", card_index, 0);
        checkOutput("midrst_rank", card_rank, 0);
        checkOutput("midrst_value", card_value, 0);
        @(negedge clk);

        // Two runs from reset with identical timing deal identical cards.
        doReset();
        for (int i = 0; i < 8; i++) begin
            drawCard(got, lat, idx, rank, value);
            run_a[i] = m_idx;
        end
        doReset();
        for (int i = 0; i < 8; i++) begin
            drawCard(got, lat, idx, rank, value);
            checkOutput("replay_index", idx, run_a[i]);
        end
        checkOutput("replay_first_index", run_a[0], 33);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
